// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the N-stage in-order core.
// Merges per-stage stall requests into a stall vector and a bubble point.
// Sequences multi-cycle flushes with a registered PC redirect, and runs a
// stall watchdog.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the stall-cycle and flush
// performance counters. When it is undefined, both counters read 0.
//
// Ports:
//   clk, rst        clock and synchronous active-low reset
//   stallreq_i      per-stage hold request (bit k = stage k)
//   flush_req_i     redirect request
//   flush_pc_i      redirect target
//   stall_o         per-stage hold (combinational, zero latency)
//   bubble_o        per-stage NOP insert (combinational, zero latency)
//   flush_o         per-stage clear to NOP (registered)
//   pc_redirect_o   PcReg loads new_pc_o (registered, first flush cycle only)
//   new_pc_o        latched redirect target
//   timeout_o       sticky stall watchdog flag
//   stall_cycles_o  perf counter: cycles with any stage stalled
//   flush_count_o   perf counter: number of redirects issued
module pipe_ctrl #(
    parameter int unsigned NUM_STAGES    = 5,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned FLUSH_HOLD    = 1,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic                  flush_req_i,
    input  logic [ADDR_W-1:0]     flush_pc_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] bubble_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  pc_redirect_o,
    output logic [ADDR_W-1:0]     new_pc_o,
    output logic                  timeout_o,
    output logic [31:0]           stall_cycles_o,
    output logic [31:0]           flush_count_o
);

    localparam int unsigned HOLD_W = 4;
    localparam int unsigned WD_REQ = $clog2(STALL_TIMEOUT + 1);
    localparam int unsigned WD_W   = (WD_REQ > 16) ? WD_REQ : 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e                  state_q;
    logic [HOLD_W-1:0]       hold_q;
    logic [NUM_STAGES-1:0]   flush_q;
    logic                    redirect_q;
    logic [ADDR_W-1:0]       new_pc_q;
    logic [WD_W-1:0]         wd_q;
    logic [WD_W-1:0]         wd_d;
    logic                    timeout_q;
    logic [NUM_STAGES-1:0]   stall_c;
    logic [NUM_STAGES-1:0]   bubble_c;
    logic                    stall_any;

    // Stall merge: every stage at or below the highest requester holds, and
    // the stage just above it takes a bubble. Gated off in reset and FLUSH.
    always_comb begin
        logic acc;
        stall_c  = '0;
        bubble_c = '0;
        acc      = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            acc        = acc | stallreq_i[i];
            stall_c[i] = acc;
        end
        for (int i = 1; i < NUM_STAGES; i++) begin
            bubble_c[i] = stall_c[i-1] & ~stall_c[i];
        end
        if (!rst || (state_q != IDLE)) begin
            stall_c  = '0;
            bubble_c = '0;
        end
    end

    assign stall_any = |stall_c;

    // Flush sequencer; a new request at any time restarts the sequence.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            flush_q    <= '0;
            redirect_q <= 1'b0;
            new_pc_q   <= '0;
        end else begin
            redirect_q <= 1'b0;
            if (flush_req_i) begin
                state_q    <= FLUSH;
                hold_q     <= HOLD_W'(FLUSH_HOLD - 1);
                flush_q    <= '1;
                redirect_q <= 1'b1;
                new_pc_q   <= flush_pc_i;
            end else if (state_q == FLUSH) begin
                if (hold_q == '0) begin
                    state_q <= IDLE;
                    flush_q <= '0;
                end else begin
                    hold_q <= hold_q - HOLD_W'(1);
                end
            end
        end
    end

    // Watchdog run-length counter, saturating, cleared by any unstalled cycle.
    always_comb begin
        wd_d = '0;
        if (stall_any) begin
            wd_d = (wd_q == '1) ? wd_q : wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            if ((STALL_TIMEOUT != 0) && (wd_d >= WD_W'(STALL_TIMEOUT))) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (stall_any) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (redirect_q) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign flush_count_o  = flush_count_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

    assign stall_o       = stall_c;
    assign bubble_o      = bubble_c;
    assign flush_o       = flush_q;
    assign pc_redirect_o = redirect_q;
    assign new_pc_o      = new_pc_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl. Two instances share one stimulus stream:
// instance 0 uses FLUSH_HOLD=1 with the watchdog disabled, and instance 1
// uses FLUSH_HOLD=3 with STALL_TIMEOUT=8. A per-instance reference model
// tracks the remaining flush cycles and the stall run length.
module tb_pipe_ctrl;

    localparam int unsigned N = 5;

    logic          clk;
    logic          rst;
    logic [N-1:0]  stallreq;
    logic          flush_req;
    logic [31:0]   flush_pc;

    logic [N-1:0]  stall_w  [2];
    logic [N-1:0]  bubble_w [2];
    logic [N-1:0]  flush_w  [2];
    logic          redir_w  [2];
    logic [31:0]   npc_w    [2];
    logic          to_w     [2];
    logic [31:0]   sc_w     [2];
    logic [31:0]   fc_w     [2];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          rem;
        bit          redir;
        logic [31:0] npc;
        int          wd;
        bit          to;
        logic [31:0] sc;
        logic [31:0] fc;
    } mdl_t;

    mdl_t m [2];
    int   hold_p [2] = '{1, 3};
    int   tmo_p  [2] = '{0, 8};

    pipe_ctrl #(.NUM_STAGES(N), .ADDR_W(32), .FLUSH_HOLD(1), .STALL_TIMEOUT(0)) u_dut0 (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .flush_req_i(flush_req),
        .flush_pc_i(flush_pc), .stall_o(stall_w[0]), .bubble_o(bubble_w[0]),
        .flush_o(flush_w[0]), .pc_redirect_o(redir_w[0]), .new_pc_o(npc_w[0]),
        .timeout_o(to_w[0]), .stall_cycles_o(sc_w[0]), .flush_count_o(fc_w[0])
    );

    pipe_ctrl #(.NUM_STAGES(N), .ADDR_W(32), .FLUSH_HOLD(3), .STALL_TIMEOUT(8)) u_dut1 (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .flush_req_i(flush_req),
        .flush_pc_i(flush_pc), .stall_o(stall_w[1]), .bubble_o(bubble_w[1]),
        .flush_o(flush_w[1]), .pc_redirect_o(redir_w[1]), .new_pc_o(npc_w[1]),
        .timeout_o(to_w[1]), .stall_cycles_o(sc_w[1]), .flush_count_o(fc_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, compare all outputs against the model, then advance
    // the model across the coming rising edge.
    task automatic cycle(input logic r, input logic [N-1:0] s, input logic f, input logic [31:0] p);
        @(negedge clk);
        rst = r; stallreq = s; flush_req = f; flush_pc = p;
        #1;
        for (int i = 0; i < 2; i++) begin
            int            k;
            logic [N-1:0]  es;
            logic [N-1:0]  eb;
            logic [31:0]   esc;
            logic [31:0]   efc;
            k = -1;
            for (int j = 0; j < int'(N); j++) if (s[j]) k = j;
            es = '0; eb = '0;
            if (r && m[i].rem == 0 && k >= 0) begin
                for (int j = 0; j <= k; j++) es[j] = 1'b1;
                if (k + 1 < int'(N)) eb[k+1] = 1'b1;
            end
`ifdef PIPE_CTRL_PERF_EN
            esc = m[i].sc; efc = m[i].fc;
`else
            esc = '0; efc = '0;
`endif
            check($sformatf("stall%0d", i),  64'(stall_w[i]),  64'(es));
            check($sformatf("bubble%0d", i), 64'(bubble_w[i]), 64'(eb));
            check($sformatf("flush%0d", i),  64'(flush_w[i]),  (m[i].rem > 0) ? 64'h1f : 64'h0);
            check($sformatf("redir%0d", i),  64'(redir_w[i]),  64'(m[i].redir));
            check($sformatf("newpc%0d", i),  64'(npc_w[i]),    64'(m[i].npc));
            check($sformatf("tmo%0d", i),    64'(to_w[i]),     64'(m[i].to));
            check($sformatf("scyc%0d", i),   64'(sc_w[i]),     64'(esc));
            check($sformatf("fcnt%0d", i),   64'(fc_w[i]),     64'(efc));
            if (!r) begin
                m[i] = '{default: 0};
            end else begin
                if (es != '0) begin
                    m[i].wd++;
                    m[i].sc = m[i].sc + 32'd1;
                end else begin
                    m[i].wd = 0;
                end
                if (tmo_p[i] != 0 && m[i].wd >= tmo_p[i]) m[i].to = 1'b1;
                if (m[i].redir) m[i].fc = m[i].fc + 32'd1;
                if (f) begin
                    m[i].rem   = hold_p[i];
                    m[i].redir = 1'b1;
                    m[i].npc   = p;
                end else begin
                    if (m[i].rem > 0) m[i].rem--;
                    m[i].redir = 1'b0;
                end
            end
        end
    endtask

    initial begin
        int nflush;
        int npulse;
        logic [31:0] exp_sc;
        logic [31:0] exp_fc;
        rst = 1'b0; stallreq = '0; flush_req = 1'b0; flush_pc = '0;
        m[0] = '{default: 0};
        m[1] = '{default: 0};
        repeat (2) @(posedge clk);

        // Reset holds everything at zero even with requests active.
        repeat (3) cycle(1'b0, 5'b11111, 1'b1, 32'hDEADBEEF);
        check("rst_stall", 64'(stall_w[1]), 64'h0);
        check("rst_npc",   64'(npc_w[1]),   64'h0);
        check("rst_flush", 64'(flush_w[0]), 64'h0);
        cycle(1'b1, 5'b11111, 1'b0, 32'h0);
        check("rel_stall",  64'(stall_w[0]),  64'h1f);
        check("rel_bubble", 64'(bubble_w[0]), 64'h0);

        // Stall merge.
        cycle(1'b1, 5'b00100, 1'b0, 32'h0);
        check("merge_s", 64'(stall_w[0]),  64'h07);
        check("merge_b", 64'(bubble_w[0]), 64'h08);
        cycle(1'b1, 5'b00101, 1'b0, 32'h0);
        check("merge2_s", 64'(stall_w[1]),  64'h07);
        check("merge2_b", 64'(bubble_w[1]), 64'h08);

        // Single-cycle flush on instance 0.
        cycle(1'b1, 5'b00000, 1'b1, 32'h1C000100);
        cycle(1'b1, 5'b00000, 1'b0, 32'h0);
        check("fl1_flush", 64'(flush_w[0]), 64'h1f);
        check("fl1_redir", 64'(redir_w[0]), 64'h1);
        check("fl1_npc",   64'(npc_w[0]),   64'h1C000100);
        cycle(1'b1, 5'b00000, 1'b0, 32'h0);
        check("fl1_done", 64'(flush_w[0]), 64'h0);
        repeat (3) cycle(1'b1, 5'b00000, 1'b0, 32'h0);

        // Restart during FLUSH on instance 1 while a stall is held.
        cycle(1'b1, 5'b00010, 1'b1, 32'hAAAA0000);
        check("rs_pre_s", 64'(stall_w[1]),  64'h03);
        check("rs_pre_b", 64'(bubble_w[1]), 64'h04);
        cycle(1'b1, 5'b00010, 1'b1, 32'hBBBB0000);
        check("rs_stall0", 64'(stall_w[1]), 64'h0);
        check("rs_npcA",   64'(npc_w[1]),   64'hAAAA0000);
        nflush = (flush_w[1] == 5'b11111) ? 1 : 0;
        npulse = redir_w[1] ? 1 : 0;
        repeat (6) begin
            cycle(1'b1, 5'b00010, 1'b0, 32'h0);
            if (flush_w[1] == 5'b11111) nflush++;
            if (redir_w[1]) npulse++;
        end
        check("rs_nflush", 64'(nflush), 64'd4);
        check("rs_npulse", 64'(npulse), 64'd2);
        check("rs_npcB",   64'(npc_w[1]), 64'hBBBB0000);
        check("rs_after",  64'(stall_w[1]), 64'h03);

        // Watchdog on instance 1.
        cycle(1'b0, 5'b00000, 1'b0, 32'h0);
        repeat (7) cycle(1'b1, 5'b00001, 1'b0, 32'h0);
        cycle(1'b1, 5'b00000, 1'b0, 32'h0);
        repeat (8) cycle(1'b1, 5'b00001, 1'b0, 32'h0);
        check("wd_before", 64'(to_w[1]), 64'h0);
        cycle(1'b1, 5'b00000, 1'b0, 32'h0);
        check("wd_set", 64'(to_w[1]), 64'h1);
        check("wd_off", 64'(to_w[0]), 64'h0);
        repeat (3) cycle(1'b1, 5'b00000, 1'b0, 32'h0);
        check("wd_sticky", 64'(to_w[1]), 64'h1);

        // Performance counters: 10 stalled cycles and 2 flushes.
        cycle(1'b0, 5'b00000, 1'b0, 32'h0);
        repeat (10) cycle(1'b1, 5'b00001, 1'b0, 32'h0);
        cycle(1'b1, 5'b00000, 1'b1, 32'h00001000);
        repeat (4) cycle(1'b1, 5'b00000, 1'b0, 32'h0);
        cycle(1'b1, 5'b00000, 1'b1, 32'h00002000);
        repeat (4) cycle(1'b1, 5'b00000, 1'b0, 32'h0);
`ifdef PIPE_CTRL_PERF_EN
        exp_sc = 32'd10; exp_fc = 32'd2;
`else
        exp_sc = 32'd0;  exp_fc = 32'd0;
`endif
        for (int i = 0; i < 2; i++) begin
            check($sformatf("perf_sc%0d", i), 64'(sc_w[i]), 64'(exp_sc));
            check($sformatf("perf_fc%0d", i), 64'(fc_w[i]), 64'(exp_fc));
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 800; n++) begin
            logic         r;
            logic [N-1:0] s;
            logic         f;
            r = ($urandom_range(0, 63) != 0);
            s = ($urandom_range(0, 1) != 0) ? N'($urandom) : '0;
            f = ($urandom_range(0, 7) == 0);
            cycle(r, s, f, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
